// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing the mmio port between the CPU (C) and debug loader (D).
// One transaction in flight; each load/store strobe reaches mmio for exactly one cycle.
module mmio_arbiter #(
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_load,
    input  logic        c_store,
    input  logic [2:0]  c_access,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_done,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_load,
    input  logic        d_store,
    input  logic [2:0]  d_access,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_load,
    output logic        m_store,
    output logic [2:0]  m_access,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        own_q, own_d;   // 0 = C, 1 = D
    logic        ptr_q, ptr_d;   // tie-break winner
    logic        ld_q, ld_d;
    logic        st_q, st_d;
    logic [2:0]  acc_q, acc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        capture;

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        ld_d      = ld_q;
        st_d      = st_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        capture   = 1'b0;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_done    = 1'b0;
        d_done    = 1'b0;
        m_load    = 1'b0;
        m_store   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (c_req || d_req) begin
                    own_d   = (c_req && d_req) ? ptr_q : !c_req;
                    // Store wins when both strobes are requested.
                    st_d    = own_d ? d_store : c_store;
                    ld_d    = own_d ? (d_load && !d_store) : (c_load && !c_store);
                    acc_d   = own_d ? d_access : c_access;
                    addr_d  = own_d ? d_addr : c_addr;
                    wdata_d = own_d ? d_wdata : c_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                c_gnt   = !own_q;
                d_gnt   = own_q;
                m_load  = ld_q;
                m_store = st_q;
                if (ld_q && RD_LATENCY != 0) begin
                    cnt_d   = 3'(RD_LATENCY - 1);
                    state_d = StWait;
                end else begin
                    capture = ld_q;
                    state_d = StResp;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                c_done  = !own_q;
                d_done  = own_q;
                ptr_d   = !own_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Load data lands in the owner's register so it is valid during the done cycle.
        if (capture) begin
            if (own_q) d_rdata_d = m_rdata;
            else       c_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            own_q     <= 1'b0;
            ptr_q     <= 1'b0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            acc_q     <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= 3'd0;
            c_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_access = acc_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: two instances (read latency 0 and 2) share stimulus and are
// checked every cycle against a transaction-timestamp model, plus directed vectors.
module tb_mmio_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c_req, c_load, c_store, d_req, d_load, d_store;
    logic [2:0]  c_access, d_access;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;

    logic        c_gnt [2];
    logic        c_done [2];
    logic [31:0] c_rdata [2];
    logic        d_gnt [2];
    logic        d_done [2];
    logic [31:0] d_rdata [2];
    logic        m_load [2];
    logic        m_store [2];
    logic [2:0]  m_access [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic        busy [2];

    mmio_arbiter #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_load(c_load), .c_store(c_store), .c_access(c_access),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt[0]), .c_done(c_done[0]),
        .c_rdata(c_rdata[0]),
        .d_req(d_req), .d_load(d_load), .d_store(d_store), .d_access(d_access),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt[0]), .d_done(d_done[0]),
        .d_rdata(d_rdata[0]),
        .m_load(m_load[0]), .m_store(m_store[0]), .m_access(m_access[0]),
        .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata), .busy(busy[0])
    );

    mmio_arbiter #(.RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_load(c_load), .c_store(c_store), .c_access(c_access),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt[1]), .c_done(c_done[1]),
        .c_rdata(c_rdata[1]),
        .d_req(d_req), .d_load(d_load), .d_store(d_store), .d_access(d_access),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt[1]), .d_done(d_done[1]),
        .d_rdata(d_rdata[1]),
        .m_load(m_load[1]), .m_store(m_store[1]), .m_access(m_access[1]),
        .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: a transaction is described by its sample cycle and kind; outputs follow from
    // the elapsed time since sampling (0 = none, 1 = load, 2 = store).
    int          lat [2];
    bit          act [2];
    int          start [2];
    bit          own [2];
    int          kind [2];
    bit          ptr [2];
    logic [2:0]  macc [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] crd [2];
    logic [31:0] drd [2];
    int          cyc = 0;

    typedef struct {
        bit          port;
        bit          ld;
        bit          st;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          done0;
        int          done2;
        int          nld;
        int          nst;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [137:0] actual, input logic [137:0] exp);
        checks++;
        if (actual !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, actual, exp);
        end
    endtask

    task automatic model_reset(input int k);
        act[k] = 1'b0;  start[k] = 0;  own[k] = 1'b0;  kind[k] = 0;  ptr[k] = 1'b0;
        macc[k] = 3'd0; maddr[k] = 32'd0; mwd[k] = 32'd0; crd[k] = 32'd0; drd[k] = 32'd0;
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int         e;
            int         len;
            bit         g;
            bit         dn;
            logic [6:0] ec;
            logic [6:0] ac;
            e   = cyc - start[k];
            len = (kind[k] == 1) ? 2 + lat[k] : 2;
            g   = act[k] && e == 1;
            dn  = act[k] && e == len;
            ec  = {act[k] && e >= 1 && e <= len, g && !own[k], g && own[k], dn && !own[k],
                   dn && own[k], g && kind[k] == 1, g && kind[k] == 2};
            ac  = {busy[k], c_gnt[k], d_gnt[k], c_done[k], d_done[k], m_load[k], m_store[k]};
            chk($sformatf("ctrl%0d@%0d", k, cyc), 138'(ac), 138'(ec));
            chk($sformatf("data%0d@%0d", k, cyc),
                {m_access[k], m_addr[k], m_wdata[k], c_rdata[k], d_rdata[k]},
                {macc[k], maddr[k], mwd[k], crd[k], drd[k]});
        end
        for (int k = 0; k < 2; k++) begin
            int e;
            int len;
            bit o;
            e   = cyc - start[k];
            len = (kind[k] == 1) ? 2 + lat[k] : 2;
            if (!rst) begin
                model_reset(k);
            end else if (!act[k]) begin
                if (c_req || d_req) begin
                    o = (c_req && d_req) ? ptr[k] : !c_req;
                    act[k] = 1'b1;  start[k] = cyc;  own[k] = o;
                    if (o) begin
                        kind[k] = d_store ? 2 : (d_load ? 1 : 0);
                        macc[k] = d_access;  maddr[k] = d_addr;  mwd[k] = d_wdata;
                    end else begin
                        kind[k] = c_store ? 2 : (c_load ? 1 : 0);
                        macc[k] = c_access;  maddr[k] = c_addr;  mwd[k] = c_wdata;
                    end
                end
            end else begin
                if (kind[k] == 1 && e == 1 + lat[k]) begin
                    if (own[k]) drd[k] = m_rdata;
                    else        crd[k] = m_rdata;
                end
                if (e == len) begin
                    act[k] = 1'b0;
                    ptr[k] = !own[k];
                end
            end
        end
        cyc++;
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (n) begin
            half();
            fin();
        end
    endtask

    task automatic run_entry(input int idx, input vec_t v);
        int gc [2];
        int dc [2];
        int nl [2];
        int ns [2];
        for (int k = 0; k < 2; k++) begin
            gc[k] = -1;  dc[k] = -1;  nl[k] = 0;  ns[k] = 0;
        end
        m_rdata = v.rdata;
        if (v.port) begin
            d_req = 1'b1; d_load = v.ld; d_store = v.st; d_access = v.acc;
            d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            c_req = 1'b1; c_load = v.ld; c_store = v.st; c_access = v.acc;
            c_addr = v.addr; c_wdata = v.wdata;
        end
        for (int j = 0; j < 7; j++) begin
            half();
            for (int k = 0; k < 2; k++) begin
                if (v.port ? d_gnt[k] : c_gnt[k]) gc[k] = j;
                if (v.port ? d_done[k] : c_done[k]) begin
                    dc[k] = j;
                    chk($sformatf("vec%0d_rdata%0d", idx, k),
                        138'(v.port ? d_rdata[k] : c_rdata[k]), 138'(v.exp_rd));
                end
                nl[k] += int'(m_load[k]);
                ns[k] += int'(m_store[k]);
            end
            fin();
            if (j == 0) begin
                c_req = 1'b0;
                d_req = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("vec%0d_gnt_cycle%0d", idx, k), 138'(gc[k]), 138'(1));
            chk($sformatf("vec%0d_done_cycle%0d", idx, k), 138'(dc[k]),
                138'(k == 1 ? v.done2 : v.done0));
            chk($sformatf("vec%0d_nload%0d", idx, k), 138'(nl[k]), 138'(v.nld));
            chk($sformatf("vec%0d_nstore%0d", idx, k), 138'(ns[k]), 138'(v.nst));
        end
    endtask

    bit seq [2][$];
    int dfirst [2];

    initial begin
        lat[0] = 0;
        lat[1] = 2;
        model_reset(0);
        model_reset(1);
        tbl[0] = '{0, 1, 0, 3'b010, 32'hfbadbedf, 32'h0, 32'h0000_1234, 2, 4, 1, 0, 32'h0000_1234};
        tbl[1] = '{1, 0, 1, 3'b010, 32'hfbadc0fe, 32'hdeadbeef, 32'h5555_5555, 2, 2, 0, 1, 32'h0};
        tbl[2] = '{1, 1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'hcafe_f00d, 2, 4, 1, 0, 32'hcafe_f00d};
        tbl[3] = '{0, 0, 1, 3'b000, 32'h0000_0003, 32'h0000_00a5, 32'h77, 2, 2, 0, 1, 32'h0000_1234};
        tbl[4] = '{0, 1, 1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h9999_9999, 2, 2, 0, 1,
                   32'h0000_1234};
        tbl[5] = '{1, 0, 0, 3'b001, 32'h0000_0020, 32'h0, 32'h0000_1111, 2, 2, 0, 0, 32'hcafe_f00d};
        tbl[6] = '{0, 1, 0, 3'b000, 32'hfbadbeef, 32'h0, 32'habcd_0001, 2, 4, 1, 0, 32'habcd_0001};

        rst = 1'b0;
        c_req = 1'b0; c_load = 1'b0; c_store = 1'b0; c_access = 3'd0; c_addr = 32'd0; c_wdata = 32'd0;
        d_req = 1'b0; d_load = 1'b0; d_store = 1'b0; d_access = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        m_rdata = 32'd0;
        fin();

        // Reset held with a pending CPU request: nothing is granted until release.
        c_req = 1'b1; c_store = 1'b1; c_addr = 32'h40;
        repeat (2) begin
            half();
            for (int k = 0; k < 2; k++) chk($sformatf("rst_gnt%0d", k), 138'(c_gnt[k]), 138'(0));
            fin();
        end
        rst = 1'b1;
        half();
        for (int k = 0; k < 2; k++) chk($sformatf("rel_gnt_early%0d", k), 138'(c_gnt[k]), 138'(0));
        fin();
        half();
        for (int k = 0; k < 2; k++) chk($sformatf("rel_gnt%0d", k), 138'(c_gnt[k]), 138'(1));
        fin();
        c_store = 1'b0;
        settle(4);

        for (int i = 0; i < 7; i++) run_entry(i, tbl[i]);
        settle(2);

        // Both ports requesting from reset: C first, then strict alternation.
        rst = 1'b0;
        half(); fin();
        rst = 1'b1;
        c_req = 1'b1; c_load = 1'b0; c_store = 1'b1; c_addr = 32'h100; c_wdata = 32'h11;
        d_req = 1'b1; d_load = 1'b0; d_store = 1'b1; d_addr = 32'h200; d_wdata = 32'h22;
        dfirst[0] = -1;
        dfirst[1] = -1;
        for (int j = 0; j < 13; j++) begin
            half();
            for (int k = 0; k < 2; k++) begin
                if (c_gnt[k]) seq[k].push_back(1'b0);
                if (d_gnt[k]) begin
                    seq[k].push_back(1'b1);
                    if (dfirst[k] < 0) dfirst[k] = j;
                end
            end
            fin();
        end
        settle(4);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("alt_count%0d", k), 138'(seq[k].size()), 138'(4));
            chk($sformatf("alt_dfirst%0d", k), 138'(dfirst[k]), 138'(4));
            for (int i = 0; i < seq[k].size() && i < 4; i++)
                chk($sformatf("alt_owner%0d_%0d", k, i), 138'(seq[k][i]), 138'(i % 2));
        end

        // Reset during the wait phase of a latency-2 load; pointer must return to C.
        c_req = 1'b1; c_load = 1'b0; c_store = 1'b1; c_addr = 32'h300;
        half(); fin();
        settle(3);
        c_req = 1'b1; c_load = 1'b1; c_store = 1'b0; c_access = 3'b000; c_addr = 32'hfbadbeef;
        m_rdata = 32'h0bad_0bad;
        half(); fin();
        c_req = 1'b0;
        half(); fin();
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            half();
            chk($sformatf("wrst_done_%0d", j), 138'(c_done[1]), 138'(0));
            fin();
        end
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            half();
            chk($sformatf("wrst_after_done_%0d", j), 138'(c_done[1]), 138'(0));
            chk($sformatf("wrst_after_strobe_%0d", j), 138'(m_load[1]), 138'(0));
            fin();
        end
        c_req = 1'b1; c_store = 1'b1; d_req = 1'b1; d_store = 1'b1;
        half(); fin();
        c_req = 1'b0; d_req = 1'b0;
        half();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wrst_cgnt%0d", k), 138'(c_gnt[k]), 138'(1));
            chk($sformatf("wrst_dgnt%0d", k), 138'(d_gnt[k]), 138'(0));
        end
        fin();
        settle(6);

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            c_req    = ($urandom_range(0, 2) != 0);
            c_load   = $urandom_range(0, 1) != 0;
            c_store  = $urandom_range(0, 1) != 0;
            c_access = 3'($urandom);
            c_addr   = $urandom;
            c_wdata  = $urandom;
            d_req    = ($urandom_range(0, 2) != 0);
            d_load   = $urandom_range(0, 1) != 0;
            d_store  = $urandom_range(0, 1) != 0;
            d_access = 3'($urandom);
            d_addr   = $urandom;
            d_wdata  = $urandom;
            m_rdata  = $urandom;
            half();
            fin();
        end
        rst = 1'b1;
        settle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
